// File: rtl/nios_tick_pkg.sv
// Shared definitions for the interval-timer tick scheduler.
// Contents:
//   state_t      - master FSM states
//   TMR_ADDR_*   - timer slave word addresses
//   CTRL_*_BIT   - timer control register bit positions
//   STATUS_RUN_BIT - timer status register RUN bit position
package nios_tick_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RD_STAT,
    ST_CHK,
    ST_RUN,
    ST_ACK,
    ST_SETTLE,
    ST_DISPATCH,
    ST_STOP
  } state_t;

  localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam int STATUS_RUN_BIT = 1;

endpackage

// File: rtl/tick_sched_channel.sv
// One software timeout channel driven by the shared timer tick.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   tick           - high for the single dispatch cycle of each timer tick
//   arm, cancel    - 1-cycle control pulses (cancel wins over arm)
//   periodic_in    - reload mode captured at arm
//   period_in      - tick count captured at arm (0 = arm ignored)
//   active         - channel armed
//   expire         - high in the dispatch cycle where the count goes 1 -> 0
module tick_sched_channel
  import nios_tick_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              arm,
  input  logic              cancel,
  input  logic              periodic_in,
  input  logic [TICK_W-1:0] period_in,
  output logic              active,
  output logic              expire
);

  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] per;
  logic              periodic;
  logic              load;
  logic              step;
  logic              last;

  // Cancel beats arm, arm beats the tick decrement.
  assign load   = arm && !cancel && (period_in != '0);
  assign step   = tick && active && !cancel && !load;
  assign last   = (cnt == TICK_W'(1));
  assign expire = step && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
    end else if (cancel) begin
      active <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
    end else if (expire && !periodic) begin
      active <= 1'b0;
    end
  end

  // Count state is only meaningful while active, so it carries no reset;
  // it also survives timer stop/restart untouched.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt      <= period_in;
      per      <= period_in;
      periodic <= periodic_in;
    end else if (step) begin
      cnt <= last ? per : cnt - TICK_W'(1);
    end
  end

endmodule

// File: rtl/nios_timer_tick_sched.sv
// Avalon-MM master for the 16-bit-register interval timer plus tick fan-out.
// Brings the timer up, verifies RUN, acks every timeout IRQ and turns each
// tick into one dispatch cycle that steps NUM_CH software timeout channels.
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   tmr_*                    - Avalon-MM master to the timer slave
//   enable                   - 1 = bring up and run, 0 = stop timer
//   ch_arm/cancel/periodic/period - per-channel control
//   ch_active, ch_expire     - per-channel status
//   tick_count               - ticks since reset
//   running, init_err        - timer verified running / bring-up failed
module nios_timer_tick_sched
  import nios_tick_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          TICK_W    = 16,
  parameter logic [15:0] PERIOD_L  = 16'h869F,
  parameter logic [15:0] PERIOD_H  = 16'h0001,
  parameter logic [3:0]  CTRL_RUN  = 4'b0111,
  parameter logic [3:0]  CTRL_STOP = 4'b1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [2:0]               tmr_address,
  output logic                     tmr_chipselect,
  output logic                     tmr_write_n,
  output logic [15:0]              tmr_writedata,
  input  logic [15:0]              tmr_readdata,
  input  logic                     tmr_irq,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_arm,
  input  logic [NUM_CH-1:0]        ch_cancel,
  input  logic [NUM_CH-1:0]        ch_periodic,
  input  logic [NUM_CH*TICK_W-1:0] ch_period,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_expire,
  output logic [31:0]              tick_count,
  output logic                     running,
  output logic                     init_err
);

  state_t state;
  logic   tick;

  assign tick = (state == ST_DISPATCH);

  // Bus outputs are registered alongside the state transition, so each
  // access strobe is visible during the cycle its state is current.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
      running        <= 1'b0;
      init_err       <= 1'b0;
      tick_count     <= '0;
    end else begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      if (tick) tick_count <= tick_count + 32'd1;
      case (state)
        ST_IDLE: begin
          if (enable && !init_err) begin
            state          <= ST_WR_PL;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_ADDR_PERIOD_L;
            tmr_writedata  <= PERIOD_L;
          end
        end
        ST_WR_PL: begin
          state          <= ST_WR_PH;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= TMR_ADDR_PERIOD_H;
          tmr_writedata  <= PERIOD_H;
        end
        ST_WR_PH: begin
          state          <= ST_WR_CTRL;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= TMR_ADDR_CONTROL;
          tmr_writedata  <= {12'd0, CTRL_RUN};
        end
        ST_WR_CTRL: begin
          state          <= ST_RD_STAT;
          tmr_chipselect <= 1'b1;
          tmr_address    <= TMR_ADDR_STATUS;
          tmr_writedata  <= '0;
        end
        ST_RD_STAT: state <= ST_CHK;
        ST_CHK: begin
          // Read data returns the cycle after the read strobe.
          if (tmr_readdata[STATUS_RUN_BIT]) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            init_err <= 1'b1;
          end
        end
        ST_RUN, ST_SETTLE, ST_DISPATCH: begin
          if (!enable) begin
            state          <= ST_STOP;
            running        <= 1'b0;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_ADDR_CONTROL;
            tmr_writedata  <= {12'd0, CTRL_STOP};
          end else if (state == ST_SETTLE) begin
            state <= ST_DISPATCH;
          end else if (state == ST_DISPATCH) begin
            state <= ST_RUN;
          end else if (tmr_irq) begin
            state          <= ST_ACK;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_ADDR_STATUS;
            tmr_writedata  <= '0;
          end
        end
        // The IRQ level drops one cycle after the status write; SETTLE
        // keeps RUN from seeing the stale level again.
        ST_ACK:  state <= ST_SETTLE;
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_sched_channel #(
      .TICK_W(TICK_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .arm        (ch_arm[i]),
      .cancel     (ch_cancel[i]),
      .periodic_in(ch_periodic[i]),
      .period_in  (ch_period[i*TICK_W +: TICK_W]),
      .active     (ch_active[i]),
      .expire     (ch_expire[i])
    );
  end

endmodule

// File: tb/tb_nios_timer_tick_sched.sv
// Testbench for nios_timer_tick_sched with a behavioural timer slave
// (timeout period shortened to 9) and table-driven channel vectors.
module tb_nios_timer_tick_sched;
  import nios_tick_pkg::*;

  localparam int          NUM_CH   = 4;
  localparam int          TICK_W   = 16;
  localparam logic [16:0] T_PERIOD = 17'd9;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [2:0]               tmr_address;
  logic                     tmr_chipselect;
  logic                     tmr_write_n;
  logic [15:0]              tmr_writedata;
  logic [15:0]              tmr_readdata;
  logic                     tmr_irq;
  logic                     enable = 1'b0;
  logic [NUM_CH-1:0]        ch_arm = '0;
  logic [NUM_CH-1:0]        ch_cancel = '0;
  logic [NUM_CH-1:0]        ch_periodic = '0;
  logic [NUM_CH*TICK_W-1:0] ch_period = '0;
  logic [NUM_CH-1:0]        ch_active;
  logic [NUM_CH-1:0]        ch_expire;
  logic [31:0]              tick_count;
  logic                     running;
  logic                     init_err;

  always #5 clk = ~clk;

  nios_timer_tick_sched #(.NUM_CH(NUM_CH), .TICK_W(TICK_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .enable(enable), .ch_arm(ch_arm), .ch_cancel(ch_cancel),
    .ch_periodic(ch_periodic), .ch_period(ch_period),
    .ch_active(ch_active), .ch_expire(ch_expire),
    .tick_count(tick_count), .running(running), .init_err(init_err)
  );

  // Timer slave model.
  logic        stat_zero = 1'b0;
  logic        t_run;
  logic [16:0] t_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_irq      <= 1'b0;
      t_run        <= 1'b0;
      t_cnt        <= '0;
      tmr_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 17'd0) begin
          tmr_irq <= 1'b1;
          t_cnt   <= T_PERIOD;
        end else begin
          t_cnt <= t_cnt - 17'd1;
        end
      end
      if (tmr_chipselect) begin
        if (!tmr_write_n) begin
          if (tmr_address == 3'd0) tmr_irq <= 1'b0;
          if (tmr_address == 3'd1) begin
            if (tmr_writedata[3]) t_run <= 1'b0;
            else if (tmr_writedata[2]) begin
              t_run <= 1'b1;
              t_cnt <= T_PERIOD;
            end
          end
        end else begin
          tmr_readdata <= stat_zero ? 16'd0 : {14'd0, t_run, tmr_irq};
        end
      end
    end
  end

  // Access log: {write, address, writedata}.
  logic [19:0] acc_q[$];
  always @(posedge clk) begin
    if (reset_n && tmr_chipselect)
      acc_q.push_back({~tmr_write_n, tmr_address, tmr_writedata});
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for n tick_count changes, counting expire pulses of channel ch.
  task automatic run_ticks(input int ch, input int n, output int nexp);
    logic [31:0] last;
    int seen, cyc;
    nexp = 0; seen = 0; cyc = 0; last = tick_count;
    while (seen < n && cyc < 40 * n + 40) begin
      @(negedge clk); cyc++;
      if (ch_expire[ch]) nexp++;
      if (tick_count != last) begin
        seen++;
        last = tick_count;
      end
    end
    if (seen < n) chk("tick_timeout", seen, n);
  endtask

  task automatic arm(input int ch, input logic [15:0] p, input logic per, input logic canc);
    ch_arm[ch] = 1'b1;
    ch_cancel[ch] = canc;
    ch_periodic[ch] = per;
    ch_period[ch*TICK_W +: TICK_W] = p;
    @(negedge clk);
    ch_arm = '0;
    ch_cancel = '0;
  endtask

  // Expects the four bring-up accesses starting at log index q, then RUN.
  task automatic check_init(input string tag, input int q);
    logic [19:0] rec;
    chk({tag, "_acc_n"}, acc_q.size() - q, 4);
    if (acc_q.size() >= q + 4) begin
      rec = acc_q[q];     chk({tag, "_wr_pl"}, rec, 20'hA869F);
      rec = acc_q[q + 1]; chk({tag, "_wr_ph"}, rec, 20'hB0001);
      rec = acc_q[q + 2]; chk({tag, "_wr_ctrl"}, rec, 20'h90007);
      rec = acc_q[q + 3]; chk({tag, "_rd_stat"}, rec[19:16], 4'h0);
    end
  endtask

  typedef struct {
    int          ch;
    logic [15:0] per;
    logic        periodic;
    int          nticks;
    int          exp_n;
    logic        exp_act;
    logic        cancel_after;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int q, cyc, n, rise, expc;
    logic prev;
    logic [19:0] rec;

    vecs[0] = '{0, 16'd3, 1'b0, 3, 1, 1'b0, 1'b0};  // one-shot expires on 3rd tick
    vecs[1] = '{1, 16'd2, 1'b1, 6, 3, 1'b1, 1'b1};  // periodic every 2nd tick
    vecs[2] = '{2, 16'd1, 1'b1, 4, 4, 1'b1, 1'b0};  // periodic every tick
    vecs[3] = '{3, 16'd5, 1'b0, 4, 0, 1'b1, 1'b0};  // not yet expired
    vecs[4] = '{0, 16'd0, 1'b1, 2, 0, 1'b0, 1'b0};  // period 0 ignored
    vecs[5] = '{2, 16'd4, 1'b0, 5, 1, 1'b0, 1'b0};  // re-arm while active restarts

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cs", tmr_chipselect, 0);
    chk("rst_write_n", tmr_write_n, 1);
    chk("rst_addr", tmr_address, 0);
    chk("rst_wdata", tmr_writedata, 0);
    chk("rst_running", running, 0);
    chk("rst_init_err", init_err, 0);
    chk("rst_active", ch_active, 0);
    chk("rst_expire", ch_expire, 0);
    chk("rst_tick_count", tick_count, 0);
    reset_n = 1'b1;

    // Status reads back RUN=0: bring-up fails and stays parked.
    stat_zero = 1'b1;
    @(negedge clk);
    q = acc_q.size();
    enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("err_init_err", init_err, 1);
    chk("err_running", running, 0);
    chk("err_state_idle", dut.state, ST_IDLE);
    check_init("err", q);
    q = acc_q.size();
    repeat (20) @(negedge clk);
    chk("err_no_more_acc", acc_q.size() - q, 0);
    reset_n = 1'b0;
    enable = 1'b0;
    stat_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_cleared_by_reset", init_err, 0);
    reset_n = 1'b1;

    // Normal bring-up: running rises 6 cycles after enable.
    @(negedge clk);
    q = acc_q.size();
    enable = 1'b1;
    cyc = 0;
    while (!running && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("init_running_cycle", cyc, 6);
    check_init("init", q);

    // Table-driven channel vectors.
    for (int i = 0; i < 6; i++) begin
      run_ticks(0, 1, n);
      arm(vecs[i].ch, vecs[i].per, vecs[i].periodic, 1'b0);
      run_ticks(vecs[i].ch, vecs[i].nticks, n);
      chk($sformatf("vec%0d_expires", i), n, vecs[i].exp_n);
      chk($sformatf("vec%0d_active", i), ch_active[vecs[i].ch], vecs[i].exp_act);
      if (vecs[i].cancel_after) begin
        ch_cancel[vecs[i].ch] = 1'b1;
        @(negedge clk);
        ch_cancel = '0;
        chk($sformatf("vec%0d_cancel", i), ch_active[vecs[i].ch], 0);
      end
    end

    // Latency from IRQ rise to expire pulse.
    run_ticks(0, 1, n);
    arm(0, 16'd1, 1'b0, 1'b0);
    prev = tmr_irq; rise = -100; expc = -1; cyc = 0;
    while (expc < 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (tmr_irq && !prev) rise = cyc;
      if (ch_expire[0]) expc = cyc;
      prev = tmr_irq;
    end
    chk("lat_irq_to_expire", expc - rise, 3);
    @(negedge clk);
    chk("lat_oneshot_cleared", ch_active[0], 0);

    // Arm and cancel in the same cycle: cancel wins.
    run_ticks(0, 1, n);
    arm(1, 16'd2, 1'b1, 1'b1);
    chk("armcancel_active", ch_active[1], 0);
    run_ticks(1, 3, n);
    chk("armcancel_expires", n, 0);
    chk("armcancel_active_late", ch_active[1], 0);

    // Stop in RUN, then restart; channel count survives.
    run_ticks(0, 1, n);
    arm(2, 16'd4, 1'b1, 1'b0);
    run_ticks(2, 1, n);
    q = acc_q.size();
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("stop_acc_n", acc_q.size() - q, 1);
    if (acc_q.size() > q) begin
      rec = acc_q[q];
      chk("stop_write", rec, 20'h90008);
    end
    chk("stop_running", running, 0);
    chk("stop_state_idle", dut.state, ST_IDLE);
    q = acc_q.size();
    enable = 1'b1;
    cyc = 0;
    while (!running && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("restart_running", running, 1);
    check_init("restart", q);
    chk("restart_ch_active", ch_active[2], 1);
    run_ticks(2, 2, n);
    chk("restart_no_early_expire", n, 0);
    run_ticks(2, 1, n);
    chk("restart_kept_count", n, 1);

    // tick_count wrap.
    @(negedge clk);
    force dut.tick_count = 32'hFFFFFFFF;
    #1;
    release dut.tick_count;
    cyc = 0;
    while (tick_count == 32'hFFFFFFFF && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    chk("tick_wrap", tick_count, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
